// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU (fetch/decode/execute/memory/write-back).
// Optional performance counters are enabled with `define MC_CTRL_PERF_EN.
module mc_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  npc_src,
  output logic [1:0]  reg_src,
  output logic [1:0]  reg_dst,
  output logic        reg_write,
  output logic [2:0]  alu_op,
  output logic        alu_src,
  output logic [1:0]  ext_op,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [31:0] cycles
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_ADDR   = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWB  = 4'd6,
    S_MEMWR  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_LUIWB  = 4'd10,
    S_TRAP   = 4'd15
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_JAL, C_JR, C_NOP, C_ILL
  } cls_t;

  state_t cur, nxt;
  cls_t   cls, dec_cls;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dec_cls = C_ILL;
    case (op)
      6'h00: begin
        case (funct)
          6'h21:   dec_cls = C_ADDU;
          6'h23:   dec_cls = C_SUBU;
          6'h08:   dec_cls = C_JR;
          6'h00:   dec_cls = C_NOP;
          default: dec_cls = C_ILL;
        endcase
      end
      6'h0d:   dec_cls = C_ORI;
      6'h23:   dec_cls = C_LW;
      6'h2b:   dec_cls = C_SW;
      6'h04:   dec_cls = C_BEQ;
      6'h0f:   dec_cls = C_LUI;
      6'h03:   dec_cls = C_JAL;
      default: dec_cls = C_ILL;
    endcase
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (dec_cls)
          C_ADDU, C_SUBU, C_ORI: nxt = S_EXEC;
          C_LW, C_SW:            nxt = S_ADDR;
          C_BEQ:                 nxt = S_BRANCH;
          C_LUI:                 nxt = S_LUIWB;
          C_JAL, C_JR:           nxt = S_JUMP;
          C_NOP:                 nxt = S_FETCH;
          default:               nxt = S_TRAP;
        endcase
      end
      S_EXEC:   nxt = S_ALUWB;
      S_ADDR:   nxt = (cls == C_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_ALUWB, S_MEMWB, S_BRANCH, S_JUMP, S_LUIWB: nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_TRAP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur     <= S_FETCH;
      cls     <= C_NOP;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        cls <= dec_cls;
        if (dec_cls == C_ILL) illegal <= 1'b1;
      end
    end
  end

  // Strobes are decoded from the state; the reset gate makes mem_req/mem_we drop the instant reset_n falls.
  always_comb begin
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    npc_src   = 2'd0;
    reg_src   = 2'd0;
    reg_dst   = 2'd0;
    reg_write = 1'b0;
    alu_op    = 3'd0;
    alu_src   = 1'b0;
    ext_op    = 2'd0;
    if (reset_n) begin
      case (cur)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          case (cls)
            C_SUBU:  alu_op = 3'd1;
            C_ORI:   begin alu_op = 3'd3; alu_src = 1'b1; ext_op = 2'd1; end
            default: alu_op = 3'd0;
          endcase
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = (cls == C_ORI) ? 2'd0 : 2'd1;
        end
        S_ADDR:  alu_src = 1'b1;
        S_MEMRD: begin mem_req = 1'b1; mem_sel = 1'b1; end
        S_MEMWB: begin reg_write = 1'b1; reg_src = 2'd1; end
        S_MEMWR: begin mem_req = 1'b1; mem_sel = 1'b1; mem_we = 1'b1; end
        S_BRANCH: begin
          alu_op   = 3'd1;
          pc_write = zero;
          npc_src  = 2'd1;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          if (cls == C_JAL) begin
            npc_src   = 2'd2;
            reg_write = 1'b1;
            reg_src   = 2'd3;
            reg_dst   = 2'd2;
          end else begin
            npc_src = 2'd3;
          end
        end
        S_LUIWB: begin
          ext_op    = 2'd2;
          reg_src   = 2'd2;
          reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = cur;

`ifdef MC_CTRL_PERF_EN
  // Any entry into FETCH from another state retires exactly one instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret <= 32'd0;
      cycles  <= 32'd0;
    end else begin
      if (cur != S_TRAP) cycles <= cycles + 32'd1;
      if (cur != S_FETCH && nxt == S_FETCH) instret <= instret + 32'd1;
    end
  end
`else
  assign instret = 32'd0;
  assign cycles  = 32'd0;
`endif

endmodule
